// File: rtl/tape_ctrl.sv
// tape_ctrl: data-tape controller for the Brainfuck core.
// Holds the cell pointer and runs the tape ops as read-modify-write cycles on
// 8-bit cells packed two per 16-bit SPRAM word. This block is the SPRAM's only master.
// Optional feature macro: TAPE_CLEAR_EN. When it is defined, the whole tape is
// swept to zero after every reset before the first op is accepted.
module tape_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [7:0]  op_arg,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_zero,
    output logic [14:0] ptr,
    output logic        clear_busy,
    output logic [13:0] ram_addr,
    output logic [3:0]  ram_we,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout
);

    localparam int PTRW  = 15;
    localparam int CELLW = 8;

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_DEC   = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd5;

`ifdef TAPE_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_RSP, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_RSP} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [CELLW-1:0] arg_q;
    logic [CELLW-1:0] cur_byte;
    logic [CELLW-1:0] new_byte;
    logic             wr_op;
    logic             accept;
`ifdef TAPE_CLEAR_EN
    logic [PTRW-2:0]  clr_cnt;
`endif

    assign accept   = op_valid && (state == S_IDLE);
    assign rsp_zero = (rsp_data == '0);

    // Select the addressed cell from the word the SPRAM returned and compute the new cell value.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        cur_byte = ptr[0] ? ram_dout[15:8] : ram_dout[7:0];
        new_byte = cur_byte;
        wr_op    = 1'b0;
        case (op_q)
            OP_INC: begin
                new_byte = cur_byte + arg_q;
                wr_op    = 1'b1;
            end
            OP_DEC: begin
                new_byte = cur_byte - arg_q;
                wr_op    = 1'b1;
            end
            OP_STORE: begin
                new_byte = arg_q;
                wr_op    = 1'b1;
            end
            default: ;  // RIGHT, LEFT, LOAD and the codes that act as LOAD leave the cell unchanged.
        endcase
    end

    // Next-state logic and SPRAM/handshake outputs for each state.
    always_comb begin
        state_nxt  = state;
        op_ready   = 1'b0;
        rsp_valid  = 1'b0;
        clear_busy = 1'b0;
        ram_addr   = ptr[PTRW-1:1];
        ram_we     = 4'b0000;
        ram_din    = {new_byte, new_byte};
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (accept) state_nxt = S_RD;
            end
            S_RD: state_nxt = S_CAP;
            S_CAP: begin
                // Write enable is gated by rst so that a reset landing in CAP cannot leave a partial write.
                if (wr_op && !rst) ram_we = ptr[0] ? 4'b1100 : 4'b0011;
                state_nxt = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
`ifdef TAPE_CLEAR_EN
            S_CLEAR: begin
                clear_busy = 1'b1;
                ram_addr   = clr_cnt;
                ram_din    = '0;
                ram_we     = rst ? 4'b0000 : 4'b1111;
                if (clr_cnt == '1) state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = RESET_STATE;
        endcase
    end

    // State register, op latch, cell pointer, response byte and clear sweep counter.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            state    <= RESET_STATE;
            op_q     <= '0;
            arg_q    <= '0;
            ptr      <= '0;
            rsp_data <= '0;
`ifdef TAPE_CLEAR_EN
            clr_cnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op_code;
                arg_q <= op_arg;
                if (op_code == OP_RIGHT) ptr <= ptr + 15'd1;
                else if (op_code == OP_LEFT) ptr <= ptr - 15'd1;
            end
            if (state == S_CAP) rsp_data <= new_byte;
`ifdef TAPE_CLEAR_EN
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 14'd1;
`endif
        end
    end

endmodule

// File: tb/tb_tape_ctrl.sv
// tb_tape_ctrl: self-checking bench for tape_ctrl.
// A byte-per-cell tape model predicts every output cycle by cycle. Directed ops
// additionally pin the model with hand-computed literal values.
// An SPRAM model with a registered read and nibble write mask stands in for the RAM.
module tb_tape_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_code = 3'd4;
    logic [7:0]  op_arg = 8'd0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_zero;
    logic [14:0] ptr;
    logic        clear_busy;
    logic [13:0] ram_addr;
    logic [3:0]  ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    tape_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_arg(op_arg), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .ptr(ptr),
        .clear_busy(clear_busy), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // SPRAM stand-in: registered read, one write-enable bit per nibble.
    logic [15:0] mem [0:16383];
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++)
            if (ram_we[n]) mem[ram_addr][n*4 +: 4] <= ram_din[n*4 +: 4];
        ram_dout <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural model: one byte per cell, and an op list with the cycle each op was accepted.
    bit [7:0] cells [0:32767];
    int       mptr = 0;
    bit [7:0] mrsp = 8'd0;
    bit       p_valid = 1'b0;
    int       p_acc, p_ptr;
    bit [7:0] p_val;
    bit       p_wr;
    bit       armed = 1'b0;
    int       cyc = 0;

    // Compare process: check the outputs every cycle, then advance the model using the inputs the next edge will sample.
    always @(negedge clk) begin
        if (armed) begin
            logic [3:0] exp_we;
            exp_we = (p_valid && cyc == p_acc + 2 && p_wr && !rst)
                   ? ((p_ptr % 2 == 1) ? 4'b1100 : 4'b0011) : 4'b0000;
            check("op_ready", op_ready, !p_valid);
            check("rsp_valid", rsp_valid, p_valid && cyc == p_acc + 3);
            check("ptr", ptr, mptr);
            check("ram_we", ram_we, exp_we);
            check("rsp_data", rsp_data, mrsp);
            check("rsp_zero", rsp_zero, mrsp == 8'd0);
            check("clear_busy", clear_busy, 1'b0);
            if (p_valid && cyc == p_acc + 1) check("rd_addr", ram_addr, p_ptr / 2);
            if (exp_we != 4'b0000) begin
                check("wr_addr", ram_addr, p_ptr / 2);
                check("ram_din", ram_din, {p_val, p_val});
            end
            if (rst) begin
                p_valid = 1'b0;
                mptr    = 0;
                mrsp    = 8'd0;
            end else begin
                if (p_valid && cyc == p_acc + 2) begin
                    if (p_wr) cells[p_ptr] = p_val;
                    mrsp = p_val;
                end
                if (p_valid && cyc == p_acc + 3) p_valid = 1'b0;
                else if (!p_valid && op_valid) begin
                    p_valid = 1'b1;
                    p_acc   = cyc;
                    p_wr    = 1'b0;
                    case (op_code)
                        3'd2: mptr = (mptr + 1) % 32768;
                        3'd3: mptr = (mptr + 32767) % 32768;
                        default: ;
                    endcase
                    p_ptr = mptr;
                    p_val = cells[mptr];
                    case (op_code)
                        3'd0: begin p_val = cells[mptr] + op_arg; p_wr = 1'b1; end
                        3'd1: begin p_val = cells[mptr] - op_arg; p_wr = 1'b1; end
                        3'd5: begin p_val = op_arg;               p_wr = 1'b1; end
                        default: ;
                    endcase
                end
            end
        end
        cyc++;
    end

    // Issue one op from IDLE (called just after a rising edge) and observe it until its response.
    task automatic do_op(input logic [2:0] c, input logic [7:0] a, output logic [7:0] d,
                         output logic z, output logic [3:0] we, output logic [15:0] din,
                         output logic [13:0] rd_addr);
        logic got;
        op_valid = 1'b1;
        op_code  = c;
        op_arg   = a;
        @(posedge clk); #1;
        op_valid = 1'b0;
        we = 4'b0000; din = 16'h0000; d = 8'h00; z = 1'b0; got = 1'b0;
        @(negedge clk);
        rd_addr = ram_addr;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ram_we != 4'b0000) begin we = ram_we; din = ram_din; end
            if (rsp_valid) begin got = 1'b1; d = rsp_data; z = rsp_zero; end
        end
        check("rsp_seen", got, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic        z;
        logic [3:0]  we;
        logic [15:0] din;
        logic [13:0] ra;

        for (int i = 0; i < 16384; i++) begin
`ifdef TAPE_CLEAR_EN
            mem[i] = 16'hA5A5;
`else
            mem[i] = 16'h0000;
`endif
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

`ifdef TAPE_CLEAR_EN
        begin
            int busy_cycles;
            int ready_seen;
            logic done;
            busy_cycles = 0; ready_seen = 0; done = 1'b0;
            for (int i = 0; i < 20000 && !done; i++) begin
                @(negedge clk);
                if (clear_busy) begin
                    busy_cycles++;
                    if (op_ready) ready_seen++;
                end else done = 1'b1;
            end
            check("clear_cycles", busy_cycles, 16384);
            check("clear_ready_low", ready_seen, 0);
            @(posedge clk); #1;
            armed = 1'b1;
            do_op(3'd4, 8'h00, d, z, we, din, ra);
            check("clr_load_0", d, 8'h00);
            do_op(3'd2, 8'h00, d, z, we, din, ra);
            check("clr_load_1", d, 8'h00);
            do_op(3'd3, 8'h00, d, z, we, din, ra);
            do_op(3'd3, 8'h00, d, z, we, din, ra);
            check("clr_ptr_7fff", ptr, 15'h7FFF);
            check("clr_load_7fff", d, 8'h00);
            do_op(3'd2, 8'h00, d, z, we, din, ra);
        end
`else
        armed = 1'b1;
        @(negedge clk);
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_ptr", ptr, 15'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_zero", rsp_zero, 1'b1);
        @(posedge clk); #1;
`endif

        // STORE 0x41 at cell 0, then read it back.
        do_op(3'd5, 8'h41, d, z, we, din, ra);
        check("store_we", we, 4'b0011);
        check("store_din", din, 16'h4141);
        do_op(3'd4, 8'h00, d, z, we, din, ra);
        check("load_41", d, 8'h41);
        check("load_41_zero", z, 1'b0);

        // Move to cell 1 and increment it three times; the high byte is written.
        do_op(3'd2, 8'h00, d, z, we, din, ra);
        check("right_ptr", ptr, 15'd1);
        for (int i = 0; i < 3; i++) do_op(3'd0, 8'h01, d, z, we, din, ra);
        check("inc_we", we, 4'b1100);
        check("inc_data", d, 8'h03);
        do_op(3'd3, 8'h00, d, z, we, din, ra);
        do_op(3'd4, 8'h00, d, z, we, din, ra);
        check("low_byte_kept", d, 8'h41);

        // LEFT from cell 0 wraps to the last cell.
        do_op(3'd3, 8'h00, d, z, we, din, ra);
        check("wrap_ptr", ptr, 15'h7FFF);
        check("wrap_addr", ra, 14'h3FFF);
        do_op(3'd1, 8'h01, d, z, we, din, ra);
        check("dec_ff", d, 8'hFF);
        check("dec_ff_zero", z, 1'b0);
        check("dec_we", we, 4'b1100);
        do_op(3'd0, 8'h01, d, z, we, din, ra);
        check("inc_00", d, 8'h00);
        check("inc_00_zero", z, 1'b1);
        do_op(3'd2, 8'h00, d, z, we, din, ra);
        check("wrap_back_ptr", ptr, 15'd0);
        check("wrap_back_addr", ra, 14'h0000);

`ifndef TAPE_CLEAR_EN
        // Reset during the CAP cycle of a STORE must suppress the write.
        op_valid = 1'b1; op_code = 3'd5; op_arg = 8'h99;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cap_we", ram_we, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(3'd4, 8'h00, d, z, we, din, ra);
        check("rst_cap_old", d, 8'h41);
`endif

        // Op code 6 acts as LOAD.
        do_op(3'd6, 8'h77, d, z, we, din, ra);
        check("code6_load", d, 8'h41);
        check("code6_we", we, 4'b0000);

        // op_valid held high with random ops; the compare process checks every cycle.
        op_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            op_code = 3'($urandom_range(0, 7));
            op_arg  = 8'($urandom);
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
